gate_logic_checker: RTL and testbench
=====================================

Name: gate_logic_checker

Overview:
- Sequential stimulus/response partner for the two-input gate block: drives operands a/b, waits for settle, then samples all seven gate outputs and checks each against internally computed expected values.
- Sweeps the full truth table (ab = 00,01,10,11) PASSES times and reports sticky per-gate failures, an error count and a pass/fail verdict.
- Sits beside the gate block as on-chip self-test / bring-up checker.

Parameters:
- SETTLE_CYCLES, 2, idle cycles between driving a/b and sampling outputs (0 legal)
- PASSES, 1, number of full 4-vector sweeps per run (>=1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin run; sampled only in IDLE
- abort  input  1  terminate run; no done pulse
- and_in, or_in, nand_in, nor_in, notb_in, xor_in, xnor_in  input  1 each  gate outputs under check
- a  output  1  operand a to gate block (registered)
- b  output  1  operand b to gate block (registered)
- busy  output  1  high from start acceptance until DONE exits
- done  output  1  one-cycle pulse at run completion
- pass  output  1  verdict; valid from done, held until next accepted start
- fail_mask  output  7  sticky per-gate mismatch flags; bit0 and, 1 or, 2 nand, 3 nor, 4 notb, 5 xor, 6 xnor
- err_count  output  8  total mismatched bit-compares, saturating at 255

Behaviour:
- Reset (async assert, sync release): state IDLE; a=b=0, busy=0, done=0, pass=0, fail_mask=0, err_count=0, vector/sweep/settle counters=0. Reset mid-run aborts immediately.
- States: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE: start=1 at edge -> APPLY; clear fail_mask, err_count, pass; vector v=0, sweep=0; busy=1. start=0 -> stay.
- Entering APPLY: a<=v[1], b<=v[0] on the same edge. APPLY lasts 1 cycle -> WAIT with settle counter = SETTLE_CYCLES; if SETTLE_CYCLES=0 -> SAMPLE directly.
- WAIT: decrement each cycle; leave to SAMPLE after exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle): expected from registered a/b: and=a&b, or=a|b, nand=~(a&b), nor=~(a|b), notb=~b, xor=a^b, xnor=~(a^b). Per mismatching bit i: fail_mask[i]<=1; err_count += popcount(mismatch), saturating at 255 (no wrap).
- After SAMPLE: if v=3 and sweep=PASSES-1 -> DONE; else v<=v+1 (3 wraps to 0 with sweep+1) -> APPLY.
- Per-vector duration SETTLE_CYCLES+2 cycles; done high in cycle after edge N = 4*PASSES*(SETTLE_CYCLES+2) counted from the start-accepting edge (defaults: 16).
- DONE (1 cycle): done=1, pass=(err_count==0 including final SAMPLE update), busy=0 on exit -> IDLE. a/b return to 0 in IDLE.
- start while busy: ignored. start and abort same cycle in IDLE: start wins, abort ignored.
- abort=1 in any non-IDLE state: next edge -> IDLE, busy=0, pass=0, no done; fail_mask/err_count retain partial values. abort takes priority over SAMPLE updates in that cycle.
- Outputs all registered; no combinational path from *_in to any output.

Test Plan:
- Ideal gate model, defaults: start pulse -> a,b sequence 00,01,10,11; done at edge 16; pass=1, fail_mask=0, err_count=0.
- xor_in stuck 0: -> mismatches on 01 and 10; fail_mask=7'b0100000, err_count=2, pass=0.
- PASSES=3, nand_in inverted: -> fail_mask=7'b0000100, err_count=12; done at edge 48.
- SETTLE_CYCLES=0: -> each vector 2 cycles, done at edge 8; start asserted during busy has no effect on timing.
- PASSES=40, all seven inputs inverted: -> 1120 mismatches, err_count saturates at 255, fail_mask=7'h7F.
- abort at edge 6 / rst_n low at edge 10 of separate runs: -> IDLE next edge / immediately, no done, pass=0, busy=0; reset also clears fail_mask and err_count.

Source files
------------

// File: rtl/gate_logic_checker.sv
// gate_logic_checker: drives a/b through the 2-input truth table, samples the seven gate outputs
// and accumulates sticky per-gate failures, a saturating error count and a pass verdict.
module gate_logic_checker #(
   parameter int SETTLE_CYCLES = 2,
   parameter int PASSES        = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       abort,
   input  logic       and_in,
   input  logic       or_in,
   input  logic       nand_in,
   input  logic       nor_in,
   input  logic       notb_in,
   input  logic       xor_in,
   input  logic       xnor_in,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [6:0] fail_mask,
   output logic [7:0] err_count
);
   localparam int SW = $clog2(PASSES + 1);
   localparam int CW = $clog2(SETTLE_CYCLES + 2);

   typedef enum logic [2:0] {IDLE, APPLY, WAIT, SAMPLE, DONE} state_t;

   state_t        state;
   logic [1:0]    v;
   logic [1:0]    v_next;
   logic [SW-1:0] sweep;
   logic [CW-1:0] cnt;
   logic [6:0]    expect_v;
   logic [6:0]    mism;
   logic [8:0]    sum;
   logic [7:0]    err_next;
   logic          last;

   // expected values come from the registered operands, so no *_in reaches an output combinationally
   always_comb begin
      expect_v = {~(a ^ b), a ^ b, ~b, ~(a | b), ~(a & b), a | b, a & b};
      mism     = expect_v ^ {xnor_in, xor_in, notb_in, nor_in, nand_in, or_in, and_in};
      sum      = {1'b0, err_count} + 9'($countones(mism));
      err_next = sum[8] ? 8'hFF : sum[7:0];
      last     = (v == 2'd3) && (sweep == SW'(PASSES - 1));
      v_next   = v + 2'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_mask <= '0;
         err_count <= '0;
         v         <= '0;
         sweep     <= '0;
         cnt       <= '0;
      end else if (state != IDLE && abort) begin
         state <= IDLE;
         a     <= 1'b0;
         b     <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               state     <= APPLY;
               fail_mask <= '0;
               err_count <= '0;
               pass      <= 1'b0;
               v         <= '0;
               sweep     <= '0;
               busy      <= 1'b1;
               a         <= 1'b0;
               b         <= 1'b0;
            end
            APPLY: begin
               cnt   <= CW'(SETTLE_CYCLES);
               state <= (SETTLE_CYCLES == 0) ? SAMPLE : WAIT;
            end
            WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) state <= SAMPLE;
            end
            SAMPLE: begin
               fail_mask <= fail_mask | mism;
               err_count <= err_next;
               if (last) begin
                  state <= DONE;
                  done  <= 1'b1;
                  pass  <= (err_next == 8'd0);
               end else begin
                  state <= APPLY;
                  v     <= v_next;
                  a     <= v_next[1];
                  b     <= v_next[0];
                  if (v == 2'd3) sweep <= sweep + SW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
               a     <= 1'b0;
               b     <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_gate_logic_checker.sv
// tb_gate_logic_checker: two checker instances (default and SETTLE=0/PASSES=40) against a faultable
// gate model; expected run results are queued and compared by a monitor on each done pulse.
module tb_gate_logic_checker;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] start = '0;
   logic [1:0] abort = '0;
   int         mode[2] = '{0, 0};
   logic [1:0] a_w, b_w, busy_w, done_w, pass_w;
   logic [6:0] g0, g1, mask0, mask1;
   logic [7:0] err0, err1;
   int         checks = 0;
   int         errors = 0;

   typedef struct {int d; logic p; logic [6:0] m; logic [7:0] e;} exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   // mode 0 ideal, 1 xor stuck at 0, 2 nand inverted, 3 every output inverted
   function automatic logic [6:0] gates(input logic x, input logic y, input int m);
      logic [6:0] g;
      g = {~(x ^ y), x ^ y, ~y, ~(x | y), ~(x & y), x | y, x & y};
      if (m == 1) g[5] = 1'b0;
      if (m == 2) g[2] = ~g[2];
      if (m == 3) g = ~g;
      return g;
   endfunction

   assign g0 = gates(a_w[0], b_w[0], mode[0]);
   assign g1 = gates(a_w[1], b_w[1], mode[1]);

   gate_logic_checker u0 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .abort(abort[0]),
      .and_in(g0[0]), .or_in(g0[1]), .nand_in(g0[2]), .nor_in(g0[3]),
      .notb_in(g0[4]), .xor_in(g0[5]), .xnor_in(g0[6]),
      .a(a_w[0]), .b(b_w[0]), .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
      .fail_mask(mask0), .err_count(err0)
   );

   gate_logic_checker #(.SETTLE_CYCLES(0), .PASSES(40)) u1 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .abort(abort[1]),
      .and_in(g1[0]), .or_in(g1[1]), .nand_in(g1[2]), .nor_in(g1[3]),
      .notb_in(g1[4]), .xor_in(g1[5]), .xnor_in(g1[6]),
      .a(a_w[1]), .b(b_w[1]), .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
      .fail_mask(mask1), .err_count(err1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   int   cyc[2];
   bit   trk[2];
   bit   prev_done[2];
   exp_t x;

   // cycle index 0 is the cycle right after the start-accepting edge
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         int per, n, vv;
         per = (i == 0) ? 4 : 2;
         n   = (i == 0) ? 16 : 320;
         if (!busy_w[i]) trk[i] = 1'b0;
         else begin
            if (!trk[i]) begin
               trk[i] = 1'b1;
               cyc[i] = 0;
            end else cyc[i]++;
            if (done_w[i]) begin
               check("done_time", 32'(cyc[i]), 32'(n));
               if (sb.size() == 0 || sb[0].d != i) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done dut%0d", i);
               end else begin
                  x = sb.pop_front();
                  check("pass", 32'(pass_w[i]), 32'(x.p));
                  check("fail_mask", 32'(i == 0 ? mask0 : mask1), 32'(x.m));
                  check("err_count", 32'(i == 0 ? err0 : err1), 32'(x.e));
               end
            end else if (cyc[i] < n) begin
               vv = (cyc[i] / per) % 4;
               check("ab_vector", 32'({a_w[i], b_w[i]}), 32'(vv));
            end else if (cyc[i] == n) check("done_missing", 32'(done_w[i]), 32'd1);
         end
         if (prev_done[i] && done_w[i]) check("done_width", 32'(done_w[i]), 32'd0);
         prev_done[i] = done_w[i];
      end
   end

   task automatic run(input int d, input int m, input logic p, input logic [6:0] mk,
                      input logic [7:0] e, input bit extra_start);
      mode[d] = m;
      sb.push_back('{d, p, mk, e});
      @(negedge clk) start[d] = 1'b1;
      @(negedge clk) start[d] = 1'b0;
      for (int k = 0; k < 400 && (sb.size() != 0 || busy_w[d]); k++) begin
         @(negedge clk);
         start[d] = extra_start && k < 200 && (k % 7 == 3);
      end
      start[d] = 1'b0;
      if (sb.size() != 0 || busy_w[d]) begin
         checks++;
         errors++;
         $display("FAIL run_timeout dut%0d busy %0b", d, busy_w[d]);
         sb.delete();
      end
      repeat (3) @(negedge clk);
      check("pass_hold", 32'(pass_w[d]), 32'(p));
      check("idle_busy", 32'(busy_w[d]), 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_ab", 32'({a_w[0], b_w[0]}), 32'd0);
      check("rst_busy", 32'(busy_w), 32'd0);
      check("rst_done", 32'(done_w), 32'd0);
      check("rst_pass", 32'(pass_w[0]), 32'd0);
      check("rst_mask", 32'(mask0), 32'd0);
      check("rst_err", 32'(err0), 32'd0);
      rst_n = 1'b1;
      run(0, 0, 1'b1, 7'h00, 8'd0, 1'b0);
      run(0, 1, 1'b0, 7'b0100000, 8'd2, 1'b0);
      run(0, 2, 1'b0, 7'b0000100, 8'd4, 1'b0);
      run(1, 3, 1'b0, 7'h7F, 8'd255, 1'b0);
      run(1, 2, 1'b0, 7'b0000100, 8'd160, 1'b0);
      run(1, 0, 1'b1, 7'h00, 8'd0, 1'b1);
      // abort sampled at edge 6: only vector 00 has been sampled
      mode[0] = 2;
      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (5) @(negedge clk);
      abort[0] = 1'b1;
      @(negedge clk) abort[0] = 1'b0;
      check("abort_busy", 32'(busy_w[0]), 32'd0);
      check("abort_pass", 32'(pass_w[0]), 32'd0);
      check("abort_mask", 32'(mask0), 32'h04);
      check("abort_err", 32'(err0), 32'd1);
      check("abort_ab", 32'({a_w[0], b_w[0]}), 32'd0);
      repeat (20) begin
         @(negedge clk);
         check("abort_no_done", 32'(done_w[0]), 32'd0);
      end
      // async reset mid-run after two sampled vectors
      mode[0] = 3;
      @(negedge clk) start[0] = 1'b1;
      @(negedge clk) start[0] = 1'b0;
      repeat (8) @(negedge clk);
      check("pre_rst_err", 32'(err0), 32'd14);
      check("pre_rst_mask", 32'(mask0), 32'h7F);
      #2 rst_n = 1'b0;
      #1;
      check("arst_busy", 32'(busy_w[0]), 32'd0);
      check("arst_mask", 32'(mask0), 32'd0);
      check("arst_err", 32'(err0), 32'd0);
      check("arst_ab", 32'({a_w[0], b_w[0]}), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (20) begin
         @(negedge clk);
         check("rst_no_done", 32'(done_w[0]), 32'd0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
